// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory port sequencer: arbitrates fetch vs. debug reads, keeps one access
// outstanding, drops stale fetch data after a redirect and aborts accesses that hang.
module imem_fetch_ctrl #(
    parameter int PC_WIDTH = 32,
    parameter int ILEN     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_fe_req,
    input  logic [PC_WIDTH-1:0] i_fe_addr,
    input  logic                i_fe_flush,
    output logic                o_fe_gnt,
    output logic                o_fe_rvalid,
    output logic [ILEN-1:0]     o_fe_data_0,
    output logic [ILEN-1:0]     o_fe_data_1,
    input  logic                i_dbg_req,
    input  logic [PC_WIDTH-1:0] i_dbg_addr,
    output logic                o_dbg_gnt,
    output logic                o_dbg_rvalid,
    output logic [ILEN-1:0]     o_dbg_data,
    output logic                o_mem_req,
    output logic [PC_WIDTH-1:0] o_mem_addr,
    input  logic                i_mem_ready,
    input  logic [ILEN-1:0]     i_mem_data_0,
    input  logic [ILEN-1:0]     i_mem_data_1,
    output logic                o_fetch_stall,
    output logic                o_timeout_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_FE  = 2'd1,
        BUSY_DBG = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    function automatic logic [PC_WIDTH-1:0] align_word(input logic [PC_WIDTH-1:0] addr);
        align_word = {addr[PC_WIDTH-1:2], 2'b00};
    endfunction

    state_t                r_state, w_state_nxt;
    logic [7:0]            r_wait, w_wait_nxt, w_wait_inc;
    logic                  w_wait_hit;
    logic                  r_fe_gnt, w_fe_gnt_nxt;
    logic                  r_dbg_gnt, w_dbg_gnt_nxt;
    logic                  r_fe_rvalid, w_fe_rvalid_nxt;
    logic                  r_dbg_rvalid, w_dbg_rvalid_nxt;
    logic [ILEN-1:0]       r_fe_data_0, w_fe_data_0_nxt;
    logic [ILEN-1:0]       r_fe_data_1, w_fe_data_1_nxt;
    logic [ILEN-1:0]       r_dbg_data, w_dbg_data_nxt;
    logic                  r_mem_req, w_mem_req_nxt;
    logic [PC_WIDTH-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic                  r_timeout, w_timeout_nxt;
    logic                  r_last_dbg, w_last_dbg_nxt;

    // The abort fires on the cycle whose stall would bring the count to MAX_WAIT;
    // a ready in that same cycle takes precedence because the hit requires !ready.
    assign w_wait_inc = r_wait + 8'd1;
    assign w_wait_hit = !i_mem_ready && (w_wait_inc == MAX_WAIT_C);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, arbitration, handshake and capture decisions.
    always_comb begin
        w_state_nxt      = r_state;
        w_wait_nxt       = r_wait;
        w_fe_gnt_nxt     = 1'b0;
        w_dbg_gnt_nxt    = 1'b0;
        w_fe_rvalid_nxt  = 1'b0;
        w_dbg_rvalid_nxt = 1'b0;
        w_fe_data_0_nxt  = r_fe_data_0;
        w_fe_data_1_nxt  = r_fe_data_1;
        w_dbg_data_nxt   = r_dbg_data;
        w_mem_req_nxt    = r_mem_req;
        w_mem_addr_nxt   = r_mem_addr;
        w_timeout_nxt    = r_timeout;
        w_last_dbg_nxt   = r_last_dbg;
        case (r_state)
            IDLE: begin
                w_mem_req_nxt = 1'b0;
                if (i_dbg_req && (!i_fe_req || !r_last_dbg)) begin
                    w_state_nxt    = BUSY_DBG;
                    w_dbg_gnt_nxt  = 1'b1;
                    w_last_dbg_nxt = 1'b1;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = align_word(i_dbg_addr);
                    w_wait_nxt     = 8'd0;
                end else if (i_fe_req) begin
                    w_state_nxt    = BUSY_FE;
                    w_fe_gnt_nxt   = 1'b1;
                    w_last_dbg_nxt = 1'b0;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = align_word(i_fe_addr);
                    w_wait_nxt     = 8'd0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY_FE: begin
                if (i_mem_ready) begin
                    w_state_nxt   = IDLE;
                    w_mem_req_nxt = 1'b0;
                    if (!i_fe_flush) begin
                        w_fe_data_0_nxt = i_mem_data_0;
                        w_fe_data_1_nxt = i_mem_data_1;
                        w_fe_rvalid_nxt = 1'b1;
                    end else begin
                        w_fe_rvalid_nxt = 1'b0;
                    end
                end else if (w_wait_hit) begin
                    w_state_nxt   = IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_timeout_nxt = 1'b1;
                end else if (i_fe_flush) begin
                    w_state_nxt = DRAIN;
                    w_wait_nxt  = 8'd0;
                end else begin
                    w_wait_nxt = w_wait_inc;
                end
            end
            BUSY_DBG: begin
                if (i_mem_ready) begin
                    w_state_nxt      = IDLE;
                    w_mem_req_nxt    = 1'b0;
                    w_dbg_data_nxt   = i_mem_data_0;
                    w_dbg_rvalid_nxt = 1'b1;
                end else if (w_wait_hit) begin
                    w_state_nxt   = IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wait_nxt = w_wait_inc;
                end
            end
            DRAIN: begin
                if (i_mem_ready) begin
                    w_state_nxt   = IDLE;
                    w_mem_req_nxt = 1'b0;
                end else if (w_wait_hit) begin
                    w_state_nxt   = IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wait_nxt = w_wait_inc;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait       <= 8'd0;
            r_fe_gnt     <= 1'b0;
            r_dbg_gnt    <= 1'b0;
            r_fe_rvalid  <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_fe_data_0  <= {ILEN{1'b0}};
            r_fe_data_1  <= {ILEN{1'b0}};
            r_dbg_data   <= {ILEN{1'b0}};
            r_mem_req    <= 1'b0;
            r_mem_addr   <= {PC_WIDTH{1'b0}};
            r_timeout    <= 1'b0;
            r_last_dbg   <= 1'b0;
        end else begin
            r_wait       <= w_wait_nxt;
            r_fe_gnt     <= w_fe_gnt_nxt;
            r_dbg_gnt    <= w_dbg_gnt_nxt;
            r_fe_rvalid  <= w_fe_rvalid_nxt;
            r_dbg_rvalid <= w_dbg_rvalid_nxt;
            r_fe_data_0  <= w_fe_data_0_nxt;
            r_fe_data_1  <= w_fe_data_1_nxt;
            r_dbg_data   <= w_dbg_data_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_timeout    <= w_timeout_nxt;
            r_last_dbg   <= w_last_dbg_nxt;
        end
    end

    assign o_fe_gnt      = r_fe_gnt;
    assign o_dbg_gnt     = r_dbg_gnt;
    assign o_fe_rvalid   = r_fe_rvalid;
    assign o_dbg_rvalid  = r_dbg_rvalid;
    assign o_fe_data_0   = r_fe_data_0;
    assign o_fe_data_1   = r_fe_data_1;
    assign o_dbg_data    = r_dbg_data;
    assign o_mem_req     = r_mem_req;
    assign o_mem_addr    = r_mem_addr;
    assign o_timeout_err = r_timeout;
    assign o_fetch_stall = i_fe_req && !r_fe_rvalid;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: per-transaction outcome rules feed expectation
// queues; a memory responder and an output monitor check the DUT independently.
module tb_imem_fetch_ctrl;

    localparam int MAXW = 15;

    logic        clk;
    logic        rst_n;
    logic        fe_req, fe_flush, dbg_req, mem_ready;
    logic [31:0] fe_addr, dbg_addr, mem_d0, mem_d1;
    logic        fe_gnt, fe_rvalid, dbg_gnt, dbg_rvalid, mem_req, fetch_stall, timeout_err;
    logic [31:0] fe_d0, fe_d1, dbg_data, mem_addr;

    imem_fetch_ctrl #(.PC_WIDTH(32), .ILEN(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_fe_req(fe_req), .i_fe_addr(fe_addr), .i_fe_flush(fe_flush),
        .o_fe_gnt(fe_gnt), .o_fe_rvalid(fe_rvalid), .o_fe_data_0(fe_d0), .o_fe_data_1(fe_d1),
        .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr),
        .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_data(dbg_data),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ready(mem_ready),
        .i_mem_data_0(mem_d0), .i_mem_data_1(mem_d1),
        .o_fetch_stall(fetch_stall), .o_timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_addr_q[$];
    logic [63:0] fe_q[$];
    logic [31:0] dbg_q[$];
    bit          m_last_dbg = 1'b0;
    bit          m_timeout = 1'b0;
    int          mem_wait = 0;
    bit          inject_ready = 1'b0;
    int          last_len = 0;
    int          last_lat = 0;
    logic        last_stall_gnt, last_rv_done, last_stall_done;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0000_0100)      return 32'h0050_0093;
        else if (a == 32'h0000_0104) return 32'h0010_0113;
        else                         return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check_all_zero();
        check("zero_ctrl", 64'({fe_gnt, fe_rvalid, dbg_gnt, dbg_rvalid, mem_req, timeout_err}), 64'd0);
        check("zero_fe_data", {fe_d0, fe_d1}, 64'd0);
        check("zero_dbg_mem", {dbg_data, mem_addr}, 64'd0);
    endtask

    // Memory model: responds mem_wait cycles after an access starts; junk data otherwise.
    initial begin : responder
        bit          active;
        int          k, lat_w;
        logic [31:0] cur;
        active = 1'b0; k = 0; lat_w = 0; cur = 32'd0;
        mem_ready = 1'b0; mem_d0 = 32'd0; mem_d1 = 32'd0;
        forever begin
            @(negedge clk);
            mem_ready = inject_ready;
            mem_d0 = $urandom;
            mem_d1 = $urandom;
            if (mem_req) begin
                if (!active) begin
                    active = 1'b1; k = 0; lat_w = mem_wait; cur = mem_addr;
                    check("mem_issue_expected", 64'(exp_addr_q.size() > 0), 64'd1);
                    if (exp_addr_q.size() > 0) check("mem_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
                end else begin
                    k++;
                    check("mem_addr_hold", 64'(mem_addr), 64'(cur));
                end
                if (k == lat_w) begin
                    mem_ready = 1'b1;
                    mem_d0 = word_at(cur);
                    mem_d1 = word_at(cur + 32'd4);
                end
                last_len = k + 1;
            end else begin
                active = 1'b0;
            end
        end
    end

    // Output monitor: every rvalid pops its owner's expectation queue.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (fe_rvalid) begin
                    check("fe_rvalid_expected", 64'(fe_q.size() > 0), 64'd1);
                    if (fe_q.size() > 0) check("fe_data", {fe_d0, fe_d1}, fe_q.pop_front());
                end
                if (dbg_rvalid) begin
                    check("dbg_rvalid_expected", 64'(dbg_q.size() > 0), 64'd1);
                    if (dbg_q.size() > 0) check("dbg_data", 64'(dbg_data), 64'(dbg_q.pop_front()));
                end
            end
        end
    end

    // One arbitration round; f = busy-cycle index of a flush pulse (-1 none), chain = new fetch raised with the flush.
    task automatic run_txn(input bit do_fe, input bit do_dbg, input logic [31:0] fa, input logic [31:0] da,
                           input int w, input int f, input bit chain, input logic [31:0] ca, input int cw);
        bit          first_dbg, fe_ok, to, pend_fe, pend_dbg, flushed, done;
        logic        exp_dbg;
        int          c, ng;
        logic [31:0] fa_al, da_al, ca_al;
        first_dbg = do_dbg && (!do_fe || !m_last_dbg);
        fa_al = fa & 32'hFFFF_FFFC;
        da_al = da & 32'hFFFF_FFFC;
        ca_al = ca & 32'hFFFF_FFFC;
        if (do_fe && !do_dbg && f >= 0 && f < w) to = (w > f + MAXW);
        else                                     to = (w >= MAXW);
        fe_ok = (w < MAXW) && (f < 0 || f > w);
        if (first_dbg) begin
            exp_addr_q.push_back(da_al);
            if (do_fe) exp_addr_q.push_back(fa_al);
        end else begin
            if (do_fe)  exp_addr_q.push_back(fa_al);
            if (do_dbg) exp_addr_q.push_back(da_al);
        end
        if (chain) exp_addr_q.push_back(ca_al);
        if (do_fe && fe_ok)  fe_q.push_back({word_at(fa_al), word_at(fa_al + 32'd4)});
        if (do_dbg && !to)   dbg_q.push_back(word_at(da_al));
        if (chain && cw < MAXW) fe_q.push_back({word_at(ca_al), word_at(ca_al + 32'd4)});
        if (to || (chain && cw >= MAXW)) m_timeout = 1'b1;
        m_last_dbg = (do_fe && do_dbg) ? !first_dbg : do_dbg;
        mem_wait = w;
        @(negedge clk);
        fe_req = do_fe; fe_addr = fa; dbg_req = do_dbg; dbg_addr = da;
        pend_fe = do_fe; pend_dbg = do_dbg; flushed = 1'b0; done = 1'b0; c = -1; ng = 0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (fe_gnt || dbg_gnt) begin
                exp_dbg = (ng == 0) ? first_dbg : (chain ? 1'b0 : !first_dbg);
                check("gnt_owner", 64'(dbg_gnt), 64'(exp_dbg));
                check("gnt_single", 64'(fe_gnt & dbg_gnt), 64'd0);
                if (fe_gnt) begin last_stall_gnt = fetch_stall; pend_fe = 1'b0; fe_req = 1'b0; end
                if (dbg_gnt) begin pend_dbg = 1'b0; dbg_req = 1'b0; end
                ng++;
                c = 0;
            end else if (c >= 0) begin
                c++;
            end
            if (!pend_fe && !pend_dbg && !mem_req) begin
                done = 1'b1; last_lat = t + 1;
                last_rv_done = fe_rvalid; last_stall_done = fetch_stall;
                fe_flush = 1'b0;
            end else if (c >= 0 && c == f && !flushed) begin
                fe_flush = 1'b1; flushed = 1'b1;
                if (chain) begin fe_req = 1'b1; fe_addr = ca; pend_fe = 1'b1; mem_wait = cw; end
            end else begin
                fe_flush = 1'b0;
            end
        end
        check("txn_done", 64'(done), 64'd1);
        check("timeout_err", 64'(timeout_err), 64'(m_timeout));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int kind, w, f;
        bit got_gnt;
        rst_n = 1'b0; fe_req = 1'b0; fe_flush = 1'b0; dbg_req = 1'b0;
        fe_addr = 32'd0; dbg_addr = 32'd0;
        repeat (3) @(negedge clk);
        check_all_zero();
        rst_n = 1'b1;

        run_txn(1'b1, 1'b0, 32'h0000_0102, 32'd0, 1, -1, 1'b0, 32'd0, 0);
        check("t1_latency", 64'(last_lat), 64'd3);
        check("t1_stall_at_gnt", 64'(last_stall_gnt), 64'd1);
        check("t1_rvalid_cycle", 64'(last_rv_done), 64'd1);
        check("t1_stall_at_rvalid", 64'(last_stall_done), 64'd0);

        run_txn(1'b1, 1'b1, 32'h0000_0300, 32'h0000_0400, 0, -1, 1'b0, 32'd0, 0);
        run_txn(1'b1, 1'b1, 32'h0000_0310, 32'h0000_0410, 0, -1, 1'b0, 32'd0, 0);

        run_txn(1'b1, 1'b0, 32'h0000_0040, 32'd0, 4, 1, 1'b1, 32'h0000_0080, 1);
        run_txn(1'b1, 1'b0, 32'h0000_0500, 32'd0, 2, 2, 1'b0, 32'd0, 0);
        run_txn(1'b0, 1'b1, 32'd0, 32'h0000_0520, 2, 1, 1'b0, 32'd0, 0);

        run_txn(1'b1, 1'b0, 32'h0000_0600, 32'd0, MAXW - 1, -1, 1'b0, 32'd0, 0);
        check("w14_len", 64'(last_len), 64'(MAXW));
        run_txn(1'b1, 1'b0, 32'h0000_0700, 32'd0, MAXW, -1, 1'b0, 32'd0, 0);
        check("timeout_len", 64'(last_len), 64'(MAXW));
        run_txn(1'b1, 1'b0, 32'h0000_0800, 32'd0, 0, -1, 1'b0, 32'd0, 0);

        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 2));
            w = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 5)) : (($urandom_range(0, 1) == 1) ? MAXW - 1 : MAXW);
            f = (kind != 2 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_txn(kind != 1, kind != 0, $urandom, $urandom, w, f, 1'b0, 32'd0, 0);
        end

        exp_addr_q.push_back(32'h0000_0900);
        mem_wait = 10;
        @(negedge clk);
        dbg_req = 1'b1; dbg_addr = 32'h0000_0902;
        got_gnt = 1'b0;
        for (int t = 0; t < 20 && !got_gnt; t++) begin
            @(negedge clk);
            if (dbg_gnt) begin got_gnt = 1'b1; dbg_req = 1'b0; end
        end
        check("t6_gnt", 64'(got_gnt), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero();
        dbg_q.delete();
        m_last_dbg = 1'b0;
        m_timeout = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        inject_ready = 1'b1;
        @(negedge clk);
        inject_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_timeout_cleared", 64'(timeout_err), 64'd0);
        check("t6_mem_idle", 64'(mem_req), 64'd0);

        check("fe_q_drained", 64'(fe_q.size()), 64'd0);
        check("dbg_q_drained", 64'(dbg_q.size()), 64'd0);
        check("addr_q_drained", 64'(exp_addr_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
